// File: rtl/draw_pkg.sv
// draw_pkg: shared constants and the ball record for the multi-ball renderer.
//   HCW/VCW  widths of the pixel counters
//   LAT      pixel-to-output latency in clock cycles
//   DW       signed width of a centre-to-pixel delta
//   D2W      width of a squared distance (no truncation)
//   RMAX     widest supported radius
//   ball_t   one ball table entry. Fields are stored at their widest supported
//            width, and narrower write ports are zero-extended into them.
package draw_pkg;

  localparam int HCW  = 12;
  localparam int VCW  = 11;
  localparam int LAT  = 3;
  localparam int DW   = 13;
  localparam int D2W  = 27;
  localparam int RMAX = 13;

  typedef struct packed {
    logic [HCW-1:0]  x;
    logic [VCW-1:0]  y;
    logic [RMAX-1:0] radius;
    logic            active;
  } ball_t;

endpackage

// File: rtl/draw_balls_pipe_dist.sv
// ball_dist_pipe: the distance pipeline for one ball. It holds stages S1 and S2.
//   clk       pixel clock
//   hcounter  pixel x, sampled at S1 together with the ball entry
//   vcounter  pixel y
//   ball      live table entry for this slot
//   d2        squared distance of the pixel from the centre (S2 output)
//   r2        squared radius (S2 output)
//   active    slot enable (S2 output)
// This block holds data only. Validity is tracked by the parent, so there is no reset here.
module ball_dist_pipe
  import draw_pkg::*;
(
  input  logic              clk,
  input  logic [HCW-1:0]    hcounter,
  input  logic [VCW-1:0]    vcounter,
  input  ball_t             ball,
  output logic [D2W-1:0]    d2,
  output logic [2*RMAX-1:0] r2,
  output logic              active
);

  logic signed [DW-1:0]  dx_q, dy_q;
  logic [2*RMAX-1:0]     r2_q;
  logic                  act_q;
  logic [2*RMAX-1:0]     rad_e;
  logic signed [D2W-1:0] dxe, dye, sq_sum;

  // Both operands are zero-extended, so the deltas are exact signed values.
  assign rad_e = {{RMAX{1'b0}}, ball.radius};

  // S1: deltas and squared radius
  always_ff @(posedge clk) begin
    dx_q  <= $signed({1'b0, hcounter}) - $signed({1'b0, ball.x});
    dy_q  <= $signed({2'b00, vcounter}) - $signed({2'b00, ball.y});
    r2_q  <= rad_e * rad_e;
    act_q <= ball.active;
  end

  // The squares are formed at full D2W width, so neither the multiply nor the add wraps.
  assign dxe    = {{(D2W-DW){dx_q[DW-1]}}, dx_q};
  assign dye    = {{(D2W-DW){dy_q[DW-1]}}, dy_q};
  assign sq_sum = dxe * dxe + dye * dye;

  // S2: squared distance
  always_ff @(posedge clk) begin
    d2     <= sq_sum;
    r2     <= r2_q;
    active <= act_q;
  end

endmodule

// File: rtl/draw_balls_pipe.sv
// draw_balls_pipe: pipelined N-ball circle renderer with shadow/live ball tables.
//   clk, rst        pixel clock and synchronous active-high reset
//   pix_valid       hcounter/vcounter carry a pixel this cycle
//   hcounter/vcounter  pixel position
//   frame_start     copies shadow to live and clears overlap_flag
//   wr_*            write one shadow slot. An out-of-range wr_idx is ignored.
//   out             COLOR if any live active ball covers the pixel
//   out_valid       pix_valid delayed by LAT cycles
//   out_idx         lowest covering slot index
//   overlap_flag    sticky flag: two or more balls covered one valid pixel this frame
// Handshake: there is no back-pressure. A pixel is accepted in every cycle
// where pix_valid=1. Exactly LAT cycles later, out_valid=1 qualifies out and
// out_idx for that pixel. When out_valid=0, out and out_idx are held at 0.
// XW <= HCW, YW <= VCW and RW <= RMAX are assumed.
module draw_balls_pipe
  import draw_pkg::*;
#(
  parameter int         N_BALLS = 4,
  parameter int         XW      = 10,
  parameter int         YW      = 10,
  parameter int         RW      = 6,
  parameter int         IDXW    = 2,
  parameter logic [3:0] COLOR   = 4'b1111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pix_valid,
  input  logic [HCW-1:0]  hcounter,
  input  logic [VCW-1:0]  vcounter,
  input  logic            frame_start,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [XW-1:0]   wr_x,
  input  logic [YW-1:0]   wr_y,
  input  logic [RW-1:0]   wr_radius,
  input  logic            wr_active,
  output logic [3:0]      out,
  output logic            out_valid,
  output logic [IDXW-1:0] out_idx,
  output logic            overlap_flag
);

  ball_t shadow_tbl [N_BALLS];
  ball_t live_tbl   [N_BALLS];

  logic [D2W-1:0]    d2     [N_BALLS];
  logic [2*RMAX-1:0] r2     [N_BALLS];
  logic              act2   [N_BALLS];
  logic              v1, v2;

  logic [N_BALLS-1:0] hit;
  logic [IDXW-1:0]    win_idx;
  logic               any_hit, multi_hit;

  // Ball tables. On a commit, live takes the shadow value from before this
  // edge, so a write in the same cycle waits for the next frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BALLS; i++) begin
        shadow_tbl[i] <= '0;
        live_tbl[i]   <= '0;
      end
    end else begin
      if (frame_start) begin
        for (int i = 0; i < N_BALLS; i++) live_tbl[i] <= shadow_tbl[i];
      end
      if (wr_en && (int'(wr_idx) < N_BALLS)) begin
        shadow_tbl[wr_idx] <= '{x:      HCW'(wr_x),
                                y:      VCW'(wr_y),
                                radius: RMAX'(wr_radius),
                                active: wr_active};
      end
    end
  end

  // Each pixel reads live_tbl in the cycle it enters S1. A commit in that
  // same cycle therefore first affects the next pixel.
  for (genvar g = 0; g < N_BALLS; g++) begin : g_ball
    ball_dist_pipe u_dist (
      .clk      (clk),
      .hcounter (hcounter),
      .vcounter (vcounter),
      .ball     (live_tbl[g]),
      .d2       (d2[g]),
      .r2       (r2[g]),
      .active   (act2[g])
    );
  end

  // S3 combinational: per-ball hits, lowest-index winner, multiple-hit detect
  always_comb begin
    hit       = '0;
    win_idx   = '0;
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    for (int i = 0; i < N_BALLS; i++) begin
      hit[i] = act2[i] && (d2[i] <= {1'b0, r2[i]});
      if (hit[i]) begin
        if (any_hit) multi_hit = 1'b1;
        else         win_idx   = IDXW'(i);
        any_hit = 1'b1;
      end
    end
  end

  // Valid pipeline, registered S3 outputs and the sticky overlap flag.
  // When overlap is set and frame_start clears in the same cycle, the set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      out_valid    <= 1'b0;
      out          <= '0;
      out_idx      <= '0;
      overlap_flag <= 1'b0;
    end else begin
      v1        <= pix_valid;
      v2        <= v1;
      out_valid <= v2;
      out       <= (v2 && any_hit) ? COLOR : 4'b0000;
      out_idx   <= v2 ? win_idx : '0;
      if (v2 && multi_hit) overlap_flag <= 1'b1;
      else if (frame_start) overlap_flag <= 1'b0;
    end
  end

endmodule
